entry_guard_ctrl: RTL and testbench
===================================

Name: entry_guard_ctrl

Overview:
- Sequencer between the keypad scanner and the password decider: forwards key events to the decider only while entry is permitted.
- Enforces an entry inactivity timeout and counts wrong-password verdicts.
- Imposes a timed lockout with a visible seconds countdown, and escalates to a latched alarm after repeated lockouts.
- Outputs feed the decider (gated key stream, abort) and the segment display (countdown, wrong count).

Parameters:
- TICK_CYCLES, 50000000, clk cycles per one-second tick (benches override small).
- IDLE_SEC, 10, seconds without a key in ENTRY before the session is aborted (1..255).
- LOCK_SEC, 30, lockout duration in seconds (1..255).
- MAX_WRONG, 3, consecutive wrong verdicts that trigger a lockout (1..15).
- ALARM_LIMIT, 2, lockouts since last success/clear that trigger ALARM (1..15).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_valid, input, 1, one-cycle pulse from the keypad scanner.
- key_code, input, 4, key value, qualified by key_valid.
- verify_done, input, 1, one-cycle pulse from the decider: verdict available.
- verify_ok, input, 1, verdict qualified by verify_done (1 = correct password).
- clear_alarm, input, 1, one-cycle admin clear pulse.
- key_out_valid, output, 1, forwarded key pulse to the decider.
- key_out_code, output, 4, forwarded key value.
- entry_abort, output, 1, one-cycle pulse telling the decider to discard partial entry.
- lockout, output, 1, high in LOCKED.
- alarm, output, 1, high in ALARM.
- countdown_sec, output, 8, remaining lockout seconds (0 outside LOCKED).
- wrong_cnt, output, 4, consecutive wrong verdicts.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; prescaler, idle timer and lockout counter cleared.
- Tick: prescaler counts 0..TICK_CYCLES-1.
  - tick is a one-cycle pulse when it wraps.
  - Prescaler is cleared on every forwarded key and on entry to LOCKED, so the first second after either is a full second.
- All outputs are registered. Forwarded key appears 1 cycle after key_valid, with key_out_code = key_code of that cycle.
- States: IDLE, ENTRY, LOCKED, ALARM.
- IDLE:
  - key_valid -> forward the key, idle timer = 0, go ENTRY.
  - verify_done is processed as in ENTRY.
- ENTRY:
  - key_valid -> forward the key, idle timer = 0.
  - tick -> idle timer +1.
  - Idle timer reaching IDLE_SEC -> entry_abort pulse for 1 cycle, go IDLE. wrong_cnt is unchanged.
- Verdict (in IDLE or ENTRY):
  - verify_ok=1 -> wrong_cnt = 0, lockout counter = 0, go IDLE.
  - verify_ok=0 -> wrong_cnt +1 (saturating at 15).
    - If the new value equals MAX_WRONG: wrong_cnt = 0, lockout counter +1, countdown_sec = LOCK_SEC, go LOCKED.
    - If the new lockout count equals ALARM_LIMIT instead: go ALARM (countdown_sec = 0).
    - Otherwise go IDLE.
- LOCKED:
  - key_valid is dropped (never forwarded); verify_done is ignored.
  - Each tick decrements countdown_sec. The transition 1 -> 0 goes IDLE with countdown_sec = 0.
- ALARM:
  - alarm=1; key_valid and verify_done are ignored.
  - clear_alarm -> wrong_cnt = 0, lockout counter = 0, go IDLE.
  - clear_alarm outside ALARM is ignored.
- Simultaneous events:
  - verify_done with key_valid in the same cycle: the verdict is processed and the key is dropped.
  - verify_done with idle expiry: the verdict wins and no entry_abort is issued.
  - tick with a forwarded key in ENTRY: the key clears the idle timer; the tick is lost.
- Reset mid-lockout or mid-alarm returns to IDLE with all counters cleared.

Test Plan:
Bench overrides: TICK_CYCLES=10, IDLE_SEC=2, LOCK_SEC=3, MAX_WRONG=3, ALARM_LIMIT=2.
- Reset, then key_valid with key_code=4'h7 -> key_out_valid=1 with key_out_code=7 exactly one cycle later; state ENTRY; all other outputs 0.
- One key, then no keys for 20 cycles -> entry_abort pulses once at cycle 20 after the forwarded key; state IDLE; wrong_cnt=0.
- Three verify_done with verify_ok=0 -> wrong_cnt reads 1, then 2, then 0; lockout=1, countdown_sec=3, stepping 3->2->1->0 every 10 cycles; lockout=0 when it reaches 0; key_valid pulses during lockout produce no key_out_valid.
- Second set of three wrong verdicts after the first lockout -> alarm=1, lockout=0, countdown_sec=0; keys are blocked; a single clear_alarm pulse -> alarm=0, wrong_cnt=0, state IDLE.
- Two wrong verdicts, then verify_ok=1 -> wrong_cnt=0; a further three wrong verdicts -> LOCKED, not ALARM, because the lockout counter was cleared.
- verify_done(ok=0) and key_valid in the same cycle -> no key_out_valid; wrong_cnt increments. Separately, rst_n=0 pulsed mid-LOCKED with countdown_sec=2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/entry_guard_ctrl.sv
// entry_guard_ctrl: gates keypad events to the password decider, enforcing entry timeout,
// wrong-verdict lockout with a seconds countdown, and a latched alarm after repeated lockouts.
module entry_guard_ctrl #(
    parameter int TICK_CYCLES = 50000000,
    parameter int IDLE_SEC    = 10,
    parameter int LOCK_SEC    = 30,
    parameter int MAX_WRONG   = 3,
    parameter int ALARM_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       verify_done,
    input  logic       verify_ok,
    input  logic       clear_alarm,
    output logic       key_out_valid,
    output logic [3:0] key_out_code,
    output logic       entry_abort,
    output logic       lockout,
    output logic       alarm,
    output logic [7:0] countdown_sec,
    output logic [3:0] wrong_cnt
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENTRY  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_ALARM  = 2'd3;
    localparam int PW = $clog2(TICK_CYCLES + 1);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);

    logic [1:0]    state, state_n;
    logic [PW-1:0] presc;
    logic [7:0]    idle_t, idle_n, cd_n;
    logic [3:0]    lock_cnt, lock_n, wrong_n, wrong_inc, lock_inc;
    logic          tick, open, fwd, verdict, abort_n, presc_clr;

    assign tick      = presc == TICK_MAX;
    assign open      = state == S_IDLE || state == S_ENTRY;
    assign verdict   = verify_done && open;
    assign fwd       = key_valid && !verify_done && open;
    assign wrong_inc = wrong_cnt == 4'hf ? wrong_cnt : wrong_cnt + 4'd1;
    assign lock_inc  = lock_cnt == 4'hf ? lock_cnt : lock_cnt + 4'd1;
    assign presc_clr = tick || fwd || (state_n == S_LOCKED && state != S_LOCKED);

    always_comb begin
        state_n = state;
        idle_n  = idle_t;
        cd_n    = countdown_sec;
        wrong_n = wrong_cnt;
        lock_n  = lock_cnt;
        abort_n = 1'b0;
        if (verdict) begin
            state_n = S_IDLE;
            if (verify_ok) begin
                wrong_n = 4'd0;
                lock_n  = 4'd0;
            end else if (wrong_inc == 4'(MAX_WRONG)) begin
                wrong_n = 4'd0;
                lock_n  = lock_inc;
                state_n = lock_inc == 4'(ALARM_LIMIT) ? S_ALARM : S_LOCKED;
                cd_n    = lock_inc == 4'(ALARM_LIMIT) ? 8'd0 : 8'(LOCK_SEC);
            end else begin
                wrong_n = wrong_inc;
            end
        end else if (fwd) begin
            idle_n  = 8'd0;
            state_n = S_ENTRY;
        end else if (state == S_ENTRY && tick) begin
            idle_n  = idle_t + 8'd1;
            abort_n = idle_n == 8'(IDLE_SEC);
            state_n = abort_n ? S_IDLE : S_ENTRY;
        end else if (state == S_LOCKED && tick) begin
            cd_n    = countdown_sec - 8'd1;
            state_n = countdown_sec == 8'd1 ? S_IDLE : S_LOCKED;
        end else if (state == S_ALARM && clear_alarm) begin
            wrong_n = 4'd0;
            lock_n  = 4'd0;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            presc         <= '0;
            idle_t        <= 8'd0;
            lock_cnt      <= 4'd0;
            key_out_valid <= 1'b0;
            key_out_code  <= 4'd0;
            entry_abort   <= 1'b0;
            lockout       <= 1'b0;
            alarm         <= 1'b0;
            countdown_sec <= 8'd0;
            wrong_cnt     <= 4'd0;
        end else begin
            state         <= state_n;
            presc         <= presc_clr ? '0 : presc + PW'(1);
            idle_t        <= idle_n;
            lock_cnt      <= lock_n;
            key_out_valid <= fwd;
            key_out_code  <= fwd ? key_code : key_out_code;
            entry_abort   <= abort_n;
            lockout       <= state_n == S_LOCKED;
            alarm         <= state_n == S_ALARM;
            countdown_sec <= cd_n;
            wrong_cnt     <= wrong_n;
        end
    end
endmodule

// File: tb/tb_entry_guard_ctrl.sv
// tb_entry_guard_ctrl: directed-vector bench for entry_guard_ctrl with small timing parameters.
module tb_entry_guard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       verify_done = 1'b0;
    logic       verify_ok = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       key_out_valid;
    logic [3:0] key_out_code;
    logic       entry_abort;
    logic       lockout;
    logic       alarm;
    logic [7:0] countdown_sec;
    logic [3:0] wrong_cnt;
    int         total = 0;
    int         passed = 0;

    entry_guard_ctrl #(
        .TICK_CYCLES(10), .IDLE_SEC(2), .LOCK_SEC(3), .MAX_WRONG(3), .ALARM_LIMIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .verify_done(verify_done), .verify_ok(verify_ok), .clear_alarm(clear_alarm),
        .key_out_valid(key_out_valid), .key_out_code(key_out_code), .entry_abort(entry_abort),
        .lockout(lockout), .alarm(alarm), .countdown_sec(countdown_sec), .wrong_cnt(wrong_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic verdict(input logic ok);
        @(negedge clk);
        verify_done = 1'b1;
        verify_ok   = ok;
        @(negedge clk);
        verify_done = 1'b0;
        verify_ok   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_kov"}, key_out_valid, 0);
        check({tag, "_abort"}, entry_abort, 0);
        check({tag, "_lock"}, lockout, 0);
        check({tag, "_alarm"}, alarm, 0);
        check({tag, "_cd"}, countdown_sec, 0);
        check({tag, "_wrong"}, wrong_cnt, 0);
    endtask

    initial begin
        step(2);
        check_quiet("rst");
        check("rst_code", key_out_code, 0);
        rst_n = 1'b1;
        // first key forwarded one cycle later
        key(4'h7);
        check("k1_kov", key_out_valid, 1);
        check("k1_code", key_out_code, 7);
        check("k1_abort", entry_abort, 0);
        check("k1_lock", lockout, 0);
        check("k1_wrong", wrong_cnt, 0);
        step(1);
        check("k1_pulse", key_out_valid, 0);
        // idle expiry 20 cycles after the forwarded key
        step(18);
        check("idle_pre", entry_abort, 0);
        step(1);
        check("idle_abort", entry_abort, 1);
        step(1);
        check("idle_post", entry_abort, 0);
        check("idle_wrong", wrong_cnt, 0);
        // first lockout
        verdict(0);
        check("w1", wrong_cnt, 1);
        verdict(0);
        check("w2", wrong_cnt, 2);
        verdict(0);
        check("w3", wrong_cnt, 0);
        check("lk_on", lockout, 1);
        check("lk_cd3", countdown_sec, 3);
        key_valid = 1'b1;
        key_code  = 4'h3;
        step(1);
        key_valid = 1'b0;
        check("lk_keydrop", key_out_valid, 0);
        step(8);
        check("lk_cd3b", countdown_sec, 3);
        step(1);
        check("lk_cd2", countdown_sec, 2);
        step(10);
        check("lk_cd1", countdown_sec, 1);
        step(9);
        check("lk_hold", lockout, 1);
        step(1);
        check("lk_cd0", countdown_sec, 0);
        check("lk_off", lockout, 0);
        // second lockout escalates to alarm
        verdict(0);
        verdict(0);
        verdict(0);
        check("al_on", alarm, 1);
        check("al_lock", lockout, 0);
        check("al_cd", countdown_sec, 0);
        check("al_wrong", wrong_cnt, 0);
        key(4'h1);
        check("al_keydrop", key_out_valid, 0);
        verdict(0);
        check("al_vdrop", wrong_cnt, 0);
        check("al_hold", alarm, 1);
        @(negedge clk);
        clear_alarm = 1'b1;
        @(negedge clk);
        clear_alarm = 1'b0;
        check("clr_alarm", alarm, 0);
        check("clr_wrong", wrong_cnt, 0);
        key(4'h9);
        check("clr_kov", key_out_valid, 1);
        check("clr_code", key_out_code, 9);
        // success clears the lockout counter
        verdict(0);
        verdict(0);
        verdict(0);
        check("ok_lk", lockout, 1);
        step(30);
        check("ok_lkoff", lockout, 0);
        verdict(0);
        verdict(0);
        check("ok_w2", wrong_cnt, 2);
        verdict(1);
        check("ok_w0", wrong_cnt, 0);
        verdict(0);
        verdict(0);
        verdict(0);
        check("ok_relock", lockout, 1);
        check("ok_noalarm", alarm, 0);
        check("ok_cd", countdown_sec, 3);
        // async reset mid-lockout
        step(10);
        check("rl_cd2", countdown_sec, 2);
        rst_n = 1'b0;
        #1;
        check_quiet("rl");
        step(1);
        rst_n = 1'b1;
        // verdict and key together: key dropped
        @(negedge clk);
        verify_done = 1'b1;
        verify_ok   = 1'b0;
        key_valid   = 1'b1;
        key_code    = 4'h5;
        @(negedge clk);
        verify_done = 1'b0;
        key_valid   = 1'b0;
        check("sim_kov", key_out_valid, 0);
        check("sim_wrong", wrong_cnt, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
